// File: rtl/kb_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : kb_scan_decoder_if
// Purpose  : Bundles the keyboard byte input, the event FIFO read port and
//            the status flags of kb_scan_decoder.
// Ports    : rx_data[8:0]  byte from the reader ([8] parity, unused)
//            rx_avail      byte-valid level, asynchronous to clk
//            rd_en         pop request for the FIFO head
//            ev_code[7:0]  head scan code      ev_ext  head had E0 prefix
//            ev_brk        head is a release   ev_valid FIFO not empty
//            fifo_full     FIFO full           overflow sticky drop flag
//            shift_held    left or right shift pressed
// Modports : master = byte source / event consumer, slave = decoder
// Revision : 1.0 - initial release
// ============================================================================
interface kb_scan_decoder_if;
  logic [8:0] rx_data;
  logic       rx_avail;
  logic       rd_en;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic       ev_valid;
  logic       fifo_full;
  logic       overflow;
  logic       shift_held;

  modport master (
    output rx_data, rx_avail, rd_en,
    input  ev_code, ev_ext, ev_brk, ev_valid, fifo_full, overflow, shift_held
  );

  modport slave (
    input  rx_data, rx_avail, rd_en,
    output ev_code, ev_ext, ev_brk, ev_valid, fifo_full, overflow, shift_held
  );
endinterface
`default_nettype wire

// File: rtl/kb_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : kb_scan_decoder
// Purpose  : Decodes PS/2 set-2 scan bytes (E0 / F0 prefixes) into
//            {ext, brk, code} events queued in a show-ahead FIFO, and tracks
//            the state of the two shift keys.
// Ports    : clk    system clock, rising edge
//            reset  asynchronous, active-high
//            bus    kb_scan_decoder_if.slave (byte input, FIFO read, flags)
// Revision : 1.0 - initial release
// ============================================================================
module kb_scan_decoder #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic               clk,
  input  logic               reset,
  kb_scan_decoder_if.slave   bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // rx_avail synchroniser and rising-edge detect
  // --------------------------------------------------------------------------
  logic sync1, sync2, sync3, rise;
  logic live;   // sync1 holds a real sample (not the reset value)
  logic armed;  // a real low level has been seen since reset

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      rise  <= 1'b0;
      live  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync1 <= bus.rx_avail;
      sync2 <= sync1;
      sync3 <= sync2;
      live  <= 1'b1;
      // A level already high at reset release must first go low, so the
      // detector stays disarmed until a genuine low sample passes through.
      armed <= armed | (live & ~sync1);
      rise  <= sync2 & ~sync3 & armed;
    end
  end

  logic       accept;
  logic [7:0] rx_byte;
  logic       unused_parity;

  assign accept        = rise;
  assign rx_byte       = bus.rx_data[7:0];
  assign unused_parity = bus.rx_data[8];

  // --------------------------------------------------------------------------
  // Prefix FSM with timeout
  // --------------------------------------------------------------------------
  state_t      state, state_nxt;
  logic [15:0] tmo, tmo_nxt;
  logic        push;
  logic        cur_ext, cur_brk;

  assign cur_ext = (state == EXT) || (state == EXT_BRK);
  assign cur_brk = (state == BRK) || (state == EXT_BRK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tmo   <= 16'd0;
    end else begin
      state <= state_nxt;
      tmo   <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_nxt   = 16'd0;
    push      = 1'b0;
    if (accept) begin
      case (rx_byte)
        8'hE0: begin
          if (state == IDLE)     state_nxt = EXT;
          else if (state == BRK) state_nxt = EXT_BRK;
        end
        8'hF0: begin
          if (state == IDLE)     state_nxt = BRK;
          else if (state == EXT) state_nxt = EXT_BRK;
        end
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
          state_nxt = IDLE;
        end
        default: begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end else if (state != IDLE) begin
      if (tmo == TIMEOUT - 16'd1) begin
        state_nxt = IDLE;
      end else begin
        tmo_nxt = tmo + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Event FIFO (show-ahead) and shift tracking
  // --------------------------------------------------------------------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, do_write, full, ovf;
  logic          shift_l, shift_r;
  logic [9:0]    head;

  assign full     = (count == FULL_CNT);
  assign pop      = bus.rd_en && (count != '0);
  // Full with a simultaneous pop frees the head slot, so the write goes ahead.
  assign do_write = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {cur_ext, cur_brk, rx_byte};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) ovf <= 1'b1;
      // Shift flags follow every decoded key, dropped or not; E0-prefixed
      // 12 is the fake shift sent around some extended keys and is ignored.
      if (push && !cur_ext) begin
        if (rx_byte == 8'h12) shift_l <= !cur_brk;
        if (rx_byte == 8'h59) shift_r <= !cur_brk;
      end
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.ev_valid   = (count != '0);
  assign bus.ev_code    = bus.ev_valid ? head[7:0] : 8'h00;
  assign bus.ev_brk     = bus.ev_valid & head[8];
  assign bus.ev_ext     = bus.ev_valid & head[9];
  assign bus.fifo_full  = full;
  assign bus.overflow   = ovf;
  assign bus.shift_held = shift_l | shift_r;

endmodule
`default_nettype wire

// File: tb/tb_kb_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_kb_scan_decoder
// Purpose  : Self-checking bench for kb_scan_decoder: table of byte
//            sequences with expected events, plus directed sequences for
//            latency, overflow, timeout and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kb_scan_decoder;

  localparam int          DEPTH = 4;
  localparam logic [15:0] TMO   = 16'd20;

  logic clk;
  logic reset;
  kb_scan_decoder_if bus ();

  kb_scan_decoder #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One rx_avail pulse carrying byte b; the byte is accepted mid-pulse.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = {1'b1, b};
    bus.rx_avail = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.rx_avail = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_one;
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [1:0] n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       ev;
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic       shift;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{2'd1, 8'h1C, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h1C, 1'b0};
    vecs[1]  = '{2'd3, 8'hE0, 8'hF0, 8'h75, 1'b1, 1'b1, 1'b1, 8'h75, 1'b0};
    vecs[2]  = '{2'd3, 8'hF0, 8'hE0, 8'h75, 1'b1, 1'b1, 1'b1, 8'h75, 1'b0};
    vecs[3]  = '{2'd3, 8'hE0, 8'hE0, 8'h6B, 1'b1, 1'b1, 1'b0, 8'h6B, 1'b0};
    vecs[4]  = '{2'd1, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1};
    vecs[5]  = '{2'd2, 8'hF0, 8'h12, 8'h00, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0};
    vecs[6]  = '{2'd2, 8'hE0, 8'h12, 8'h00, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0};
    vecs[7]  = '{2'd1, 8'h59, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h59, 1'b1};
    vecs[8]  = '{2'd3, 8'hE0, 8'hF0, 8'h59, 1'b1, 1'b1, 1'b1, 8'h59, 1'b1};
    vecs[9]  = '{2'd2, 8'hF0, 8'h59, 8'h00, 1'b1, 1'b0, 1'b1, 8'h59, 1'b0};
    vecs[10] = '{2'd1, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{2'd3, 8'hF0, 8'hAA, 8'h1C, 1'b1, 1'b0, 1'b0, 8'h1C, 1'b0};
    vecs[12] = '{2'd3, 8'hE0, 8'h00, 8'h74, 1'b1, 1'b0, 1'b0, 8'h74, 1'b0};

    bus.rx_data  = 9'h000;
    bus.rx_avail = 1'b0;
    bus.rd_en    = 1'b0;
    reset        = 1'b1;
    idle(3);
    check("reset_outputs",
          {bus.ev_valid, bus.fifo_full, bus.overflow, bus.shift_held,
           bus.ev_ext, bus.ev_brk, bus.ev_code}, 32'h0);
    reset = 1'b0;
    idle(5);

    // ---- latency: ev_valid on the 4th edge after avail is first sampled
    @(negedge clk);
    bus.rx_data  = 9'h01C;
    bus.rx_avail = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("latency_edge3", bus.ev_valid, 1'b0);
    @(posedge clk);
    #1 check("latency_edge4", bus.ev_valid, 1'b1);
    check("latency_event", {bus.ev_ext, bus.ev_brk, bus.ev_code}, {2'b00, 8'h1C});
    idle(8);
    check("level_no_repeat", 32'(dut.count), 32'd1);
    @(negedge clk);
    bus.rx_avail = 1'b0;
    idle(6);
    pop_one();
    check("latency_pop_empty", bus.ev_valid, 1'b0);
    pop_one();
    check("pop_while_empty", bus.ev_valid, 1'b0);

    // ---- table of byte sequences
    for (int i = 0; i < NV; i++) begin
      send_byte(vecs[i].b0);
      if (vecs[i].n > 2'd1) send_byte(vecs[i].b1);
      if (vecs[i].n > 2'd2) send_byte(vecs[i].b2);
      check($sformatf("vec%0d_valid", i), bus.ev_valid, vecs[i].ev);
      check($sformatf("vec%0d_shift", i), bus.shift_held, vecs[i].shift);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_event", i), {bus.ev_ext, bus.ev_brk, bus.ev_code},
              {vecs[i].ext, vecs[i].brk, vecs[i].code});
        pop_one();
        check($sformatf("vec%0d_single", i), bus.ev_valid, 1'b0);
      end
    end

    // ---- overflow: DEPTH+1 makes, no reads
    for (int i = 0; i < DEPTH; i++) send_byte(8'h15 + 8'(i));
    check("full_before_ovf", {bus.fifo_full, bus.overflow}, 2'b10);
    send_byte(8'h15 + 8'(DEPTH));
    check("full_after_ovf", {bus.fifo_full, bus.overflow}, 2'b11);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovf_read%0d", i), {bus.ev_valid, bus.ev_code}, {1'b1, 8'h15 + 8'(i)});
      pop_one();
    end
    check("ovf_drained", {bus.ev_valid, bus.fifo_full, bus.overflow}, 3'b001);

    // ---- timeout: F0, long gap, 1C is a make
    send_byte(8'hF0);
    idle(int'(TMO) + 5);
    send_byte(8'h1C);
    check("timeout_event", {bus.ev_valid, bus.ev_ext, bus.ev_brk, bus.ev_code},
          {3'b100, 8'h1C});
    pop_one();

    // ---- reset mid-sequence
    send_byte(8'h12);
    send_byte(8'hE0);
    check("pre_reset_state", {bus.ev_valid, bus.shift_held, bus.overflow}, 3'b111);
    @(negedge clk);
    reset = 1'b1;
    #1 check("in_reset_outputs",
             {bus.ev_valid, bus.fifo_full, bus.overflow, bus.shift_held,
              bus.ev_ext, bus.ev_brk, bus.ev_code}, 32'h0);
    idle(3);
    reset = 1'b0;
    idle(5);
    send_byte(8'h1C);
    check("post_reset_event", {bus.ev_valid, bus.ev_ext, bus.ev_brk, bus.ev_code},
          {3'b100, 8'h1C});
    pop_one();

    // ---- avail already high at reset release is not a byte
    @(negedge clk);
    reset        = 1'b1;
    bus.rx_data  = 9'h033;
    bus.rx_avail = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(12);
    check("held_avail_ignored", bus.ev_valid, 1'b0);
    bus.rx_avail = 1'b0;
    idle(6);
    send_byte(8'h33);
    check("held_avail_next", {bus.ev_valid, bus.ev_ext, bus.ev_brk, bus.ev_code},
          {3'b100, 8'h33});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
